// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
//   state_t          : controller states STOP / RUN / PEND
//   CLK_DIV_W        : default width of the half-period terminal count
//   CLK_DEFAULT_DIV  : default terminal count loaded at reset (divide-by-8)
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int unsigned CLK_DIV_W       = 8;
  localparam int unsigned CLK_DEFAULT_DIV = 3;

endpackage

// File: rtl/div_counter.sv
// Half-period counter for the clock divider.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : hold count at zero (has priority over en)
//   en       : advance count this cycle
//   limit    : terminal count; count runs 0..limit then wraps
//   term     : count currently equals limit
module div_counter
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = CLK_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] limit,
  output logic             term
);

  logic [DIV_W-1:0] count;

  assign term = (count == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= term ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with a valid/ready configuration port.
// clk_out half-period is active_div+1 clk cycles. A new divide value taken
// while running is held in pend_div and only applied at the next falling
// boundary of clk_out, so no phase in progress is ever shortened or stretched.
//   clk, rst   : clock, asynchronous active-high reset
//   enable     : level request to run the divided clock
//   cfg_valid  : cfg_div offered
//   cfg_div    : new terminal count
//   cfg_ready  : configuration can be accepted (low while a value is pending)
//   clk_out    : registered divided clock
//   tick       : one-cycle pulse in the first cycle clk_out reads 1
//   active_div : terminal count currently in use
//   running    : state is RUN or PEND
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W       = CLK_DIV_W,
  parameter int unsigned DEFAULT_DIV = CLK_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] active_div,
  output logic             running
);

  state_t           state, state_n;
  logic             clk_out_n;
  logic             tick_n;
  logic [DIV_W-1:0] active_n;
  logic [DIV_W-1:0] pend_div, pend_n;
  logic             term;
  logic             xfer;

  div_counter #(
    .DIV_W(DIV_W)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == STOP),
    .en   (state != STOP),
    .limit(active_div),
    .term (term)
  );

  assign cfg_ready = (state != PEND);
  assign running   = (state != STOP);
  assign xfer      = cfg_valid && cfg_ready;

  always_comb begin
    state_n   = state;
    clk_out_n = clk_out;
    active_n  = active_div;
    pend_n    = pend_div;
    unique case (state)
      STOP: begin
        clk_out_n = 1'b0;
        // A transfer is loaded first; enable is honoured on the next cycle.
        if (xfer) begin
          active_n = cfg_div;
        end else if (enable) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (term) begin
          clk_out_n = !clk_out;
        end
        if (term && clk_out && !enable) begin
          // Stopping on this falling boundary: a value accepted on the same
          // cycle is applied directly, as a pending value would have been.
          state_n = STOP;
          if (xfer) begin
            active_n = cfg_div;
          end
        end else if (xfer) begin
          pend_n  = cfg_div;
          state_n = PEND;
        end
      end
      PEND: begin
        if (term) begin
          clk_out_n = !clk_out;
        end
        if (term && clk_out) begin
          active_n = pend_div;
          state_n  = enable ? RUN : STOP;
        end
      end
      default: begin
        state_n   = STOP;
        clk_out_n = 1'b0;
      end
    endcase
    tick_n = clk_out_n && !clk_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= STOP;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      active_div <= DIV_W'(DEFAULT_DIV);
      pend_div   <= '0;
    end else begin
      state      <= state_n;
      clk_out    <= clk_out_n;
      tick       <= tick_n;
      active_div <= active_n;
      pend_div   <= pend_n;
    end
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of the half-period terminal-count field.
REQ-002 SHALL have parameter DEFAULT_DIV, default 3: terminal count loaded at reset (divide-by-8, half-period 4 cycles).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port enable  input  1  level request to run the divided clock.
REQ-006 SHALL have port cfg_valid  input  1  new divide value offered.
REQ-007 SHALL have port cfg_div  input  DIV_W  new terminal count; half-period = cfg_div+1 clk cycles.
REQ-008 SHALL have port cfg_ready  output  1  block can accept cfg_div.
REQ-009 SHALL have port clk_out  output  1  registered divided clock.
REQ-010 SHALL have port tick  output  1  one-cycle pulse coincident with each clk_out 0->1 transition.
REQ-011 SHALL have port active_div  output  DIV_W  terminal count currently in use.
REQ-012 SHALL have port running  output  1  high in states RUN and PEND.

Function
REQ-013 SHALL implement states STOP, RUN, PEND; no other reachable states.
REQ-014 SHALL, in RUN/PEND, increment count each cycle; at count==active_div ("terminal"), count wraps to 0 and clk_out toggles.
REQ-015 SHALL hold count at 0 and clk_out at 0 in STOP.
REQ-016 SHALL, in STOP with enable=1, enter RUN next cycle with count=0 and clk_out=0 (low phase first).
REQ-017 SHALL perform a handshake transfer only on cycles with cfg_valid=1 and cfg_ready=1; cfg_div is sampled on that cycle.
REQ-018 SHALL drive cfg_ready=1 in STOP and RUN, and 0 in PEND.
REQ-019 SHALL, on a transfer in STOP, load active_div next cycle and stay in STOP.
REQ-020 SHALL, on a transfer in RUN, store cfg_div in pend_div and enter PEND next cycle.
REQ-021 SHALL, in PEND, apply pend_div only at a terminal with clk_out=1 (falling boundary): clk_out->0, count->0, active_div->pend_div, state->RUN.
REQ-022 SHALL never shorten or lengthen a half-period already in progress; every clk_out high and low phase equals active_div+1 cycles of the value current at its start.
REQ-023 SHALL, when enable=0 in RUN, continue until the next terminal with clk_out=1, then drive clk_out=0 and enter STOP; no runt high pulse.
REQ-024 SHALL, when enable=0 in PEND, apply pend_div and enter STOP at the same falling boundary.
REQ-025 SHALL, when enable=0 at a terminal with clk_out=0, continue through the full high phase first.
REQ-026 SHALL treat cfg_div=0 as divide-by-2: clk_out toggles every cycle.
REQ-027 SHALL assert tick in the same cycle that the registered clk_out first reads 1.

Reset
REQ-028 SHALL, while rst=1, asynchronously force state=STOP, count=0, clk_out=0, tick=0, active_div=DEFAULT_DIV, pend_div=0, and running=0; cfg_ready SHALL read 1 as a consequence of STOP.
REQ-029 SHALL abandon any pending configuration when rst asserts mid-operation; the first post-reset cycle behaves per REQ-016/REQ-019.

Structure
REQ-030 SHALL place the state encoding (STOP/RUN/PEND) and the DIV_W/DEFAULT_DIV defaults in shared package clk_div_pkg.
REQ-031 SHALL implement count, the terminal compare and wrap in one sub-module div_counter (inputs clr, en, limit; output term); the FSM, handshake and clk_out register stay in clk_div_ctrl.

Verification
REQ-032 SHALL cover reset then enable=1 with DEFAULT_DIV=3 -> clk_out low 4 cycles, high 4 cycles, period 8; tick on every rise; running=1.
REQ-033 SHALL cover a transfer of cfg_div=1 during the high phase in RUN -> cfg_ready=0 until the falling edge; then 2-cycle phases; active_div=1; cfg_ready=1 the cycle after.
REQ-034 SHALL cover enable dropped during a low phase, cfg_div=3 -> the high phase completes at 4 cycles, clk_out=0, STOP, and no further ticks.
REQ-035 SHALL cover cfg_div=0 in STOP, then enable -> active_div=0 next cycle; clk_out toggles every cycle after the start.
REQ-036 SHALL cover enable=0 on the same cycle as a pending cfg_div=5 and a terminal with clk_out=1 -> STOP with active_div=5.
REQ-037 SHALL cover rst asserted in PEND mid-phase -> outputs reach reset values immediately without waiting for clk; pend_div is discarded; active_div=3.
